// File: rtl/player_heart_ctrl.sv
// player_heart_ctrl: fight-box heart movement, HP/invulnerability FSM and sprite pixel lookup
module player_heart_ctrl #(
    parameter int SPR_W     = 31,
    parameter int SPR_H     = 27,
    parameter int ADDR_W    = 10,
    parameter int STEP      = 5,
    parameter int BOX_X0    = 220,
    parameter int BOX_X1    = 420,
    parameter int BOX_Y0    = 160,
    parameter int BOX_Y1    = 320,
    parameter int START_X   = 305,
    parameter int START_Y   = 227,
    parameter int HP_W      = 4,
    parameter int HP_MAX    = 10,
    parameter int INV_TICKS = 60,
    parameter int BLINK_SH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [3:0]        key,
    input  logic [1:0]        state,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              collision,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              player_on,
    output logic [HP_W-1:0]   hp,
    output logic              invuln,
    output logic              dead
);
    localparam int INV_W = ($clog2(INV_TICKS + 1) > BLINK_SH) ? $clog2(INV_TICKS + 1) : BLINK_SH + 1;
    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic signed [10:0] X_LO = 11'(BOX_X0);
    localparam logic signed [10:0] X_HI = 11'(BOX_X1 - SPR_W);
    localparam logic signed [10:0] Y_LO = 11'(BOX_Y0);
    localparam logic signed [10:0] Y_HI = 11'(BOX_Y1 - SPR_H);

    typedef enum logic [1:0] {ALIVE, HIT, DEAD} fsm_t;
    fsm_t fsm;

    logic [9:0]        x_reg, y_reg, x_nx, y_nx, dx, dy;
    logic [INV_W-1:0]  inv_cnt;
    logic              fight_q, col_q, hit_q;
    logic              fight, restart, hit, move, in_box;
    logic signed [10:0] x_s, y_s, x_mv, y_mv;
    logic [ADDR_W-1:0] addr;

    always_comb begin
        fight   = state == 2'd1;
        restart = reset || (fight && !fight_q);
        hit     = hit_q && fight && fsm == ALIVE;
        move    = tick && fight && fsm != DEAD;
        x_s     = $signed({1'b0, x_reg});
        y_s     = $signed({1'b0, y_reg});
        // opposite keys on one axis cancel out
        x_mv    = (key[1] && !key[0]) ? x_s + STEP_S : (key[0] && !key[1]) ? x_s - STEP_S : x_s;
        y_mv    = (key[2] && !key[3]) ? y_s + STEP_S : (key[3] && !key[2]) ? y_s - STEP_S : y_s;
        x_nx    = x_mv < X_LO ? X_LO[9:0] : x_mv > X_HI ? X_HI[9:0] : x_mv[9:0];
        y_nx    = y_mv < Y_LO ? Y_LO[9:0] : y_mv > Y_HI ? Y_HI[9:0] : y_mv[9:0];
        dx      = x - x_reg;
        dy      = y - y_reg;
        in_box  = fight && x >= x_reg && {1'b0, x} < {1'b0, x_reg} + 11'(SPR_W)
                        && y >= y_reg && {1'b0, y} < {1'b0, y_reg} + 11'(SPR_H);
        addr    = ADDR_W'(32'(dy) * SPR_W + 32'(dx));
    end

    assign invuln = fsm == HIT;
    assign dead   = fsm == DEAD;

    always_ff @(posedge clk) begin
        fight_q <= fight;
        if (restart) begin
            x_reg     <= 10'(START_X);
            y_reg     <= 10'(START_Y);
            hp        <= HP_W'(HP_MAX);
            inv_cnt   <= '0;
            fsm       <= ALIVE;
            col_q     <= 1'b0;
            hit_q     <= 1'b0;
            player_on <= 1'b0;
            rom_addr  <= '0;
        end else begin
            col_q     <= collision;
            hit_q     <= collision && !col_q;
            player_on <= in_box && !(fsm == HIT && inv_cnt[BLINK_SH]);
            rom_addr  <= in_box ? addr : '0;
            if (move) begin
                x_reg <= x_nx;
                y_reg <= y_nx;
            end
            if (hit) begin
                hp <= hp == '0 ? '0 : hp - HP_W'(1);
                if (hp <= HP_W'(1)) begin
                    fsm     <= DEAD;
                    inv_cnt <= '0;
                end else begin
                    fsm     <= HIT;
                    inv_cnt <= INV_W'(INV_TICKS);
                end
            end else if (fsm == HIT && tick && fight) begin
                inv_cnt <= inv_cnt - INV_W'(1);
                if (inv_cnt == INV_W'(1))
                    fsm <= ALIVE;
            end
        end
    end
endmodule

// File: tb/tb_player_heart_ctrl.sv
// tb_player_heart_ctrl: randomized checks of player_heart_ctrl against an integer reference model
module tb_player_heart_ctrl;
    localparam int SPR_W = 31, SPR_H = 27, STEP = 5;
    localparam int BX0 = 220, BX1 = 420, BY0 = 160, BY1 = 320;
    localparam int SX = 305, SY = 227, HPM = 10, INV = 60, BSH = 2, ADDR_W = 10;

    logic       clk = 1'b0, reset = 1'b1, tick = 1'b0, collision = 1'b0;
    logic [3:0] key = 4'd0;
    logic [1:0] state = 2'd0;
    logic [9:0] x = 10'd0, y = 10'd0;
    logic [9:0] rom_addr;
    logic       player_on, invuln, dead;
    logic [3:0] hp;

    always #5 clk = ~clk;

    player_heart_ctrl dut (
        .clk(clk), .reset(reset), .tick(tick), .key(key), .state(state),
        .x(x), .y(y), .collision(collision), .rom_addr(rom_addr),
        .player_on(player_on), .hp(hp), .invuln(invuln), .dead(dead)
    );

    int n_cmp = 0, n_bad = 0;
    int m_x = SX, m_y = SY, m_hp = HPM, m_inv = 0, e_on = 0, e_addr = 0;
    bit m_pf = 0, m_col = 0, m_pend = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction

    // Advance the reference by one clock using the inputs held across the edge.
    task automatic model();
        bit fight, respawn, inb, hidden, hit_now;
        int dxs, dys;
        fight   = state == 2'd1;
        respawn = reset || (fight && !m_pf);
        m_pf    = fight;
        if (respawn) begin
            m_x = SX; m_y = SY; m_hp = HPM; m_inv = 0;
            m_col = 0; m_pend = 0; e_on = 0; e_addr = 0;
            return;
        end
        inb = fight && int'(x) >= m_x && int'(x) < m_x + SPR_W && int'(y) >= m_y && int'(y) < m_y + SPR_H;
        hidden  = m_inv > 0 && ((m_inv >> BSH) & 1) == 1;
        e_on    = inb && !hidden;
        e_addr  = inb ? (((int'(y) - m_y) * SPR_W + (int'(x) - m_x)) & ((1 << ADDR_W) - 1)) : 0;
        hit_now = m_pend && fight && m_inv == 0 && m_hp > 0;
        m_pend  = collision && !m_col;
        m_col   = collision;
        if (tick && fight && m_hp > 0) begin
            dxs = (key[1] && !key[0]) ? STEP : (key[0] && !key[1]) ? -STEP : 0;
            dys = (key[2] && !key[3]) ? STEP : (key[3] && !key[2]) ? -STEP : 0;
            m_x = clampi(m_x + dxs, BX0, BX1 - SPR_W);
            m_y = clampi(m_y + dys, BY0, BY1 - SPR_H);
        end
        if (hit_now) begin
            m_hp--;
            m_inv = m_hp > 0 ? INV : 0;
        end else if (m_inv > 0 && tick && fight) begin
            m_inv--;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model();
        check("hp", int'(hp), m_hp);
        check("dead", int'(dead), int'(m_hp == 0));
        check("invuln", int'(invuln), int'(m_inv > 0));
        check("player_on", int'(player_on), e_on);
        check("rom_addr", int'(rom_addr), e_addr);
    endtask

    task automatic run_random(input int cycles, input int tick_pct, input int fight_pct,
                              input int rst_permil, input int col_flip);
        for (int i = 0; i < cycles; i++) begin
            reset = $urandom_range(0, 999) < rst_permil;
            state = ($urandom_range(0, 99) < fight_pct) ? 2'd1 : 2'($urandom_range(0, 3));
            tick  = $urandom_range(0, 99) < tick_pct;
            key   = 4'($urandom);
            if ($urandom_range(0, col_flip - 1) == 0) collision = ~collision;
            x = 10'(m_x - 4 + int'($urandom_range(0, SPR_W + 8)));
            y = 10'(m_y - 4 + int'($urandom_range(0, SPR_H + 8)));
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        step();
        check("rst_hp", int'(hp), 10);
        check("rst_dead", int'(dead), 0);
        check("rst_invuln", int'(invuln), 0);
        check("rst_on", int'(player_on), 0);
        reset = 1'b0;
        state = 2'd1;
        key   = 4'b0001;
        tick  = 1'b1;
        for (int i = 0; i < 20; i++) step();
        tick = 1'b0; key = 4'b0000; x = 10'd220; y = 10'd227;
        step();
        check("clamp_left_on", int'(player_on), 1);
        check("clamp_left_addr", int'(rom_addr), 0);
        key = 4'b0011; tick = 1'b1;
        for (int i = 0; i < 3; i++) step();
        tick = 1'b0; x = 10'd219;
        step();
        check("both_keys_edge", int'(player_on), 0);
        state = 2'd0;
        step();
        state = 2'd1;
        step();
        x = 10'd305; y = 10'd227;
        step();
        check("spawn_on", int'(player_on), 1);
        check("spawn_addr", int'(rom_addr), 0);
        x = 10'd335; y = 10'd253;
        step();
        check("corner_addr", int'(rom_addr), 836);
        x = 10'd336;
        step();
        check("past_edge_on", int'(player_on), 0);
        key = 4'b1010; tick = 1'b1;
        for (int i = 0; i < 101; i++) step();
        tick = 1'b0; key = 4'b0000; x = 10'd389; y = 10'd160;
        step();
        check("diag_clamp_on", int'(player_on), 1);
        check("diag_clamp_addr", int'(rom_addr), 0);

        run_random(3000, 25, 97, 2, 16);
        reset = 1'b0; state = 2'd1;
        run_random(2500, 100, 100, 0, 8);
        check("dead_reached", int'(dead), 1);
        state = 2'd0; collision = 1'b0;
        step();
        state = 2'd1;
        step();
        check("respawn_hp", int'(hp), 10);
        check("respawn_dead", int'(dead), 0);
        run_random(3000, 30, 95, 1, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
